vga_tty_writer: RTL and testbench
=================================

// Module: vga_tty_writer
// PURPOSE
//  Terminal-style writer for the VGA character memory: accepts a byte stream (CPU/UART console) and
//  turns it into single-cell write commands (we, wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color).
//  Tracks the cursor, interprets control bytes and clears rows on line advance. Sits between the
//  console source and the character memory's write port.
// PARAMETERS
//  COLS  70  visible columns; column index range [0, COLS)
//  ROWS  30  visible rows; row index range [0, ROWS)
// PORTS
//  clk         in   1  single clock; all state updates on posedge clk
//  rst         in   1  reset, asynchronous, active-high
//  in_valid    in   1  byte available
//  in_ready    out  1  byte accepted when in_valid & in_ready
//  in_ascii    in   8  byte to print / control code
//  in_fg       in   3  foreground colour, sampled with the byte
//  in_bg       in   3  background colour, sampled with the byte
//  we          out  1  write strobe to character memory, one cycle per cell
//  wr_addr     out  5  target row
//  wc_addr     out  7  target column
//  w_ascii     out  8  character to store
//  w_fg_color  out  3  foreground colour to store
//  w_bg_color  out  3  background colour to store
//  cur_row     out  5  cursor row
//  cur_col     out  7  cursor column
// BEHAVIOUR
//  - Reset: we=0, wr_addr/wc_addr/w_ascii/w_fg_color/w_bg_color=0, cur_row=cur_col=0, in_ready=0 while rst high.
//  - States: IDLE (in_ready=1), CLEAR (in_ready=0, one space write per cycle). Write outputs registered.
//  - Accept in IDLE; write for the byte appears on the next cycle (latency 1), we high exactly 1 cycle.
//  - 0x20..0x7E: write byte at (cur_row,cur_col) with sampled colours; cur_col+1.
//    If cur_col was COLS-1: cur_col=0, row advance.
//  - 0x0A LF: cur_col=0, row advance; no character write. 0x0D CR: cur_col=0, no write.
//  - 0x08 BS: if cur_col>0: cur_col-1, write 0x20 at new column; at col 0: no-op (no wrap to previous row).
//  - Any other byte: consumed, no write, cursor unchanged.
//  - Row advance: cur_row = (cur_row==ROWS-1) ? 0 : cur_row+1 (wrap, no scroll), then CLEAR.
//  - CLEAR: writes 0x20 to columns 0..COLS-1 of new row, one per cycle, colours = sampled byte's
//    colours; exactly COLS we pulses, then IDLE. Cursor already at (new row, 0) throughout.
//  - Back-to-back: printable bytes accepted every cycle in IDLE; input stalls only during CLEAR.
//  - Reset mid-CLEAR: abort immediately, cursor to (0,0), no further writes from the aborted clear.
//  - Address widths: column counter 7 bits, row counter 5 bits; COLS<=128, ROWS<=32.
// CONFIGURATION
//  VGA_TTY_INIT_CLEAR_EN defined: after reset deassert, state INIT writes 0x20 (fg=7, bg=0) to all
//    ROWS*COLS cells, row-major, one per cycle, in_ready=0; then IDLE.
//    Reset during INIT restarts it.
//  Undefined: IDLE directly after reset; screen contents untouched.
// STRUCTURE
//  Package vga_tty_pkg: state enum (INIT, IDLE, CLEAR), CH_LF/CH_CR/CH_BS/CH_SPACE constants,
//    COLS/ROWS default constants.
//  Sub-module vga_tty_cursor: row/column counters with inc/dec/cr/advance controls and wrap logic;
//    top level holds FSM, clear counter and registered write port.
// TESTING
//  1. Reset, send 'A'(fg=2,bg=1) -> next cycle we=1, (0,0), w_ascii=0x41, fg=2, bg=1; cursor (0,1).
//  2. Send COLS printable bytes from (0,0) -> last written at (0,COLS-1); then COLS clear writes on row 1; cursor (1,0).
//  3. Cursor (ROWS-1,5), send 0x0A -> COLS writes of 0x20 on row 0, in_ready=0 for COLS cycles; cursor (0,0).
//  4. Cursor (3,4): send 0x08 -> write 0x20 at (3,3); cursor (3,3). At (3,0): 0x08 -> no write.
//  5. Send 0x0D at (2,9) -> cursor (2,0), no write; send 0x07 -> consumed, no write, cursor unchanged.
//  6. Assert rst mid-CLEAR -> we=0 same cycle, cursor (0,0); with VGA_TTY_INIT_CLEAR_EN: ROWS*COLS writes then in_ready=1.

Source files
------------

// File: rtl/vga_tty_pkg.sv
// +--------------------------------------------------------------------------+
// | Module : vga_tty_pkg                                                     |
// | Desc   : Shared constants and helpers for the VGA terminal writer.       |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package vga_tty_pkg;

  localparam int COLS_DEFAULT = 70;
  localparam int ROWS_DEFAULT = 30;
  localparam int COL_W        = 7;
  localparam int ROW_W        = 5;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [2:0] INIT_FG = 3'd7;
  localparam logic [2:0] INIT_BG = 3'd0;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_tty_cursor.sv
// +--------------------------------------------------------------------------+
// | Module : vga_tty_cursor                                                  |
// | Desc   : Cursor row/column counters with advance, backspace and wrap.    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_tty_cursor
  import vga_tty_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             cr,
  input  logic             adv,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             at_last_col
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [ROW_W-1:0] row_q, row_d, next_row;
  logic [COL_W-1:0] col_q, col_d;

  assign at_last_col = (col_q == LAST_COL);
  // No scrolling: the bottom row wraps back to the top of the screen.
  assign next_row    = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (adv || (inc && at_last_col)) begin
      row_d = next_row;
      col_d = '0;
    end else if (inc) begin
      col_d = col_q + 1'b1;
    end else if (dec && (col_q != '0)) begin
      col_d = col_q - 1'b1;
    end else if (cr) begin
      col_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

`default_nettype wire

// File: rtl/vga_tty_writer.sv
// +--------------------------------------------------------------------------+
// | Module : vga_tty_writer                                                  |
// | Desc   : Byte-stream terminal writer producing character-memory writes.  |
// |          Define VGA_TTY_INIT_CLEAR_EN to blank the screen after reset.   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_tty_writer
  import vga_tty_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_ascii,
  input  logic [2:0]       in_fg,
  input  logic [2:0]       in_bg,
  output logic             we,
  output logic [ROW_W-1:0] wr_addr,
  output logic [COL_W-1:0] wc_addr,
  output logic [7:0]       w_ascii,
  output logic [2:0]       w_fg_color,
  output logic [2:0]       w_bg_color,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
`ifdef VGA_TTY_INIT_CLEAR_EN
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [1:0]       RST_STATE = ST_INIT;
`else
  localparam logic [1:0]       RST_STATE = ST_IDLE;
`endif

  logic [1:0]       state_q, state_d;
  logic [COL_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [2:0]       clr_fg_q, clr_fg_d;
  logic [2:0]       clr_bg_q, clr_bg_d;
  logic             we_q, we_d;
  logic [ROW_W-1:0] wr_addr_q, wr_addr_d;
  logic [COL_W-1:0] wc_addr_q, wc_addr_d;
  logic [7:0]       w_ascii_q, w_ascii_d;
  logic [2:0]       w_fg_q, w_fg_d;
  logic [2:0]       w_bg_q, w_bg_d;
`ifdef VGA_TTY_INIT_CLEAR_EN
  logic [ROW_W-1:0] init_row_q, init_row_d;
`endif

  logic             accept;
  logic             cur_inc, cur_dec, cur_cr, cur_adv;
  logic             cur_last_col;

  vga_tty_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk         (clk),
    .rst         (rst),
    .inc         (cur_inc),
    .dec         (cur_dec),
    .cr          (cur_cr),
    .adv         (cur_adv),
    .row         (cur_row),
    .col         (cur_col),
    .at_last_col (cur_last_col)
  );

  // Gate with rst so the reset state reports not-ready even when it is IDLE.
  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_fg_d  = clr_fg_q;
    clr_bg_d  = clr_bg_q;
    we_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wc_addr_d = wc_addr_q;
    w_ascii_d = w_ascii_q;
    w_fg_d    = w_fg_q;
    w_bg_d    = w_bg_q;
    cur_inc   = 1'b0;
    cur_dec   = 1'b0;
    cur_cr    = 1'b0;
    cur_adv   = 1'b0;
`ifdef VGA_TTY_INIT_CLEAR_EN
    init_row_d = init_row_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(in_ascii)) begin
            we_d      = 1'b1;
            wr_addr_d = cur_row;
            wc_addr_d = cur_col;
            w_ascii_d = in_ascii;
            w_fg_d    = in_fg;
            w_bg_d    = in_bg;
            cur_inc   = 1'b1;
            if (cur_last_col) begin
              state_d   = ST_CLEAR;
              clr_cnt_d = '0;
              clr_fg_d  = in_fg;
              clr_bg_d  = in_bg;
            end
          end else if (in_ascii == CH_LF) begin
            cur_adv   = 1'b1;
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            clr_fg_d  = in_fg;
            clr_bg_d  = in_bg;
          end else if (in_ascii == CH_CR) begin
            cur_cr = 1'b1;
          end else if ((in_ascii == CH_BS) && (cur_col != '0)) begin
            cur_dec   = 1'b1;
            we_d      = 1'b1;
            wr_addr_d = cur_row;
            wc_addr_d = cur_col - 1'b1;
            w_ascii_d = CH_SPACE;
            w_fg_d    = in_fg;
            w_bg_d    = in_bg;
          end
        end
      end

      // Cursor already sits on the new row, so it doubles as the clear target.
      ST_CLEAR: begin
        we_d      = 1'b1;
        wr_addr_d = cur_row;
        wc_addr_d = clr_cnt_q;
        w_ascii_d = CH_SPACE;
        w_fg_d    = clr_fg_q;
        w_bg_d    = clr_bg_q;
        if (clr_cnt_q == LAST_COL) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

`ifdef VGA_TTY_INIT_CLEAR_EN
      ST_INIT: begin
        we_d      = 1'b1;
        wr_addr_d = init_row_q;
        wc_addr_d = clr_cnt_q;
        w_ascii_d = CH_SPACE;
        w_fg_d    = INIT_FG;
        w_bg_d    = INIT_BG;
        if (clr_cnt_q == LAST_COL) begin
          clr_cnt_d  = '0;
          init_row_d = init_row_q + 1'b1;
          if (init_row_q == LAST_ROW) begin
            state_d    = ST_IDLE;
            init_row_d = '0;
          end
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      clr_fg_q  <= '0;
      clr_bg_q  <= '0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wc_addr_q <= '0;
      w_ascii_q <= '0;
      w_fg_q    <= '0;
      w_bg_q    <= '0;
`ifdef VGA_TTY_INIT_CLEAR_EN
      init_row_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      clr_fg_q  <= clr_fg_d;
      clr_bg_q  <= clr_bg_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wc_addr_q <= wc_addr_d;
      w_ascii_q <= w_ascii_d;
      w_fg_q    <= w_fg_d;
      w_bg_q    <= w_bg_d;
`ifdef VGA_TTY_INIT_CLEAR_EN
      init_row_q <= init_row_d;
`endif
    end
  end

  assign we         = we_q;
  assign wr_addr    = wr_addr_q;
  assign wc_addr    = wc_addr_q;
  assign w_ascii    = w_ascii_q;
  assign w_fg_color = w_fg_q;
  assign w_bg_color = w_bg_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_tty_writer.sv
// +--------------------------------------------------------------------------+
// | Module : tb_vga_tty_writer                                               |
// | Desc   : Self-checking bench for vga_tty_writer (honours                 |
// |          VGA_TTY_INIT_CLEAR_EN when defined).                            |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vga_tty_writer;

  localparam int COLS = 70;
  localparam int ROWS = 30;
  localparam int GUARD = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_ascii = 8'h00;
  logic [2:0] in_fg = 3'd0;
  logic [2:0] in_bg = 3'd0;
  logic       we;
  logic [4:0] wr_addr;
  logic [6:0] wc_addr;
  logic [7:0] w_ascii;
  logic [2:0] w_fg_color;
  logic [2:0] w_bg_color;
  logic [4:0] cur_row;
  logic [6:0] cur_col;

  vga_tty_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ascii   (in_ascii),
    .in_fg      (in_fg),
    .in_bg      (in_bg),
    .we         (we),
    .wr_addr    (wr_addr),
    .wc_addr    (wc_addr),
    .w_ascii    (w_ascii),
    .w_fg_color (w_fg_color),
    .w_bg_color (w_bg_color),
    .cur_row    (cur_row),
    .cur_col    (cur_col)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected cell writes, each tagged with the sample cycle it must be seen on.
  typedef struct {
    int r; int c; int a; int fg; int bg; int due;
  } wr_t;
  wr_t q[$];
  int  m_row = 0;
  int  m_col = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_wr(input int r, input int c, input int a, input int fg, input int bg, input int due);
    wr_t w;
    w.r = r; w.c = c; w.a = a; w.fg = fg; w.bg = bg; w.due = due;
    q.push_back(w);
  endtask

  task automatic model_row_advance(input int fg, input int bg, input int first_due);
    m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    m_col = 0;
    for (int k = 0; k < COLS; k++) push_wr(m_row, k, 8'h20, fg, bg, first_due + k);
  endtask

  // Terminal rules applied to one accepted byte; e = cycle count before the accepting edge.
  task automatic model_byte(input int b, input int fg, input int bg, input int e);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(m_row, m_col, b, fg, bg, e + 1);
      if (m_col == COLS - 1) model_row_advance(fg, bg, e + 2);
      else m_col++;
    end else if (b == 8'h0A) begin
      model_row_advance(fg, bg, e + 2);
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_wr(m_row, m_col, 8'h20, fg, bg, e + 1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_write: row %0d col %0d due cycle %0d not seen", q[0].r, q[0].c, q[0].due);
        void'(q.pop_front());
      end
      n_checks++;
      if (q.size() > 0 && q[0].due == cyc) begin
        if (we !== 1'b1 || wr_addr != q[0].r[4:0] || wc_addr != q[0].c[6:0] ||
            w_ascii != q[0].a[7:0] || w_fg_color != q[0].fg[2:0] || w_bg_color != q[0].bg[2:0]) begin
          n_fail++;
          $display("FAIL cell_write: got we=%0b (%0d,%0d) ch=%02h fg=%0d bg=%0d expected we=1 (%0d,%0d) ch=%02h fg=%0d bg=%0d",
                   we, wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color,
                   q[0].r, q[0].c, q[0].a, q[0].fg, q[0].bg);
        end
        void'(q.pop_front());
      end else if (we !== 1'b0) begin
        n_fail++;
        $display("FAIL spurious_write: got we=%0b at (%0d,%0d) expected we=0", we, wr_addr, wc_addr);
      end
    end
  end

  task automatic send(input int b, input int fg, input int bg);
    int g;
    int e;
    in_valid = 1'b1;
    in_ascii = b[7:0];
    in_fg    = fg[2:0];
    in_bg    = bg[2:0];
    g = 0;
    while (!in_ready && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    if (g >= GUARD) begin
      check("send_ready_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      e = cyc;
      model_byte(b, fg, bg, e);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic check_cur(input string name, input int r, input int c);
    check({name, "_row"}, int'(cur_row), r);
    check({name, "_col"}, int'(cur_col), c);
    check({name, "_model"}, m_row * 1000 + m_col, r * 1000 + c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    q.delete();
    m_row = 0;
    m_col = 0;
    #1;
    check("rst_we", int'(we), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_cursor", int'({cur_row, cur_col}), 0);
    check("rst_wport", int'({wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color}), 0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
`ifdef VGA_TTY_INIT_CLEAR_EN
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        push_wr(r, c, 8'h20, 7, 0, cyc + 1 + r * COLS + c);
`endif
    @(negedge clk);
  endtask

  initial begin
    int n;

    // Test 1: single printable byte, latency one cycle.
    do_reset();
    send(8'h41, 2, 1);
    check("t1_we", int'(we), 1);
    check("t1_addr", int'({wr_addr, wc_addr}), 0);
    check("t1_ascii", int'(w_ascii), 8'h41);
    check("t1_colors", int'({w_fg_color, w_bg_color}), {3'd2, 3'd1});
    check_cur("t1_cur", 0, 1);

    // Test 2: full line then automatic wrap and clear of row 1.
    do_reset();
    for (int i = 0; i < COLS; i++) send(8'h61 + (i % 26), i % 8, (i + 3) % 8);
    check("t2_last_col", int'(wc_addr), COLS - 1);
    check("t2_last_row", int'(wr_addr), 0);
    n = 0;
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t2_clear_cycles", n, COLS);
    check_cur("t2_cur", 1, 0);

    // Test 3: line feed on the bottom row wraps to row 0.
    for (int i = 0; i < ROWS - 2; i++) send(8'h0A, 4, 3);
    for (int i = 0; i < 5; i++) send(8'h30 + i, 1, 6);
    check_cur("t3_pre", ROWS - 1, 5);
    send(8'h0A, 6, 2);
    n = 0;
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t3_stall_cycles", n, COLS);
    check_cur("t3_cur", 0, 0);

    // Test 4: backspace at column 0 and mid-line.
    for (int i = 0; i < 3; i++) send(8'h0A, 0, 0);
    send(8'h08, 3, 3);
    check("t4_bs_col0_we", int'(we), 0);
    check_cur("t4_bs_col0_cur", 3, 0);
    for (int i = 0; i < 4; i++) send(8'h7E, 5, 4);
    send(8'h08, 2, 5);
    check("t4_bs_we", int'(we), 1);
    check("t4_bs_addr", int'({wr_addr, wc_addr}), int'({5'd3, 7'd3}));
    check("t4_bs_ascii", int'(w_ascii), 8'h20);
    check_cur("t4_cur", 3, 3);

    // Test 5: unknown control byte then carriage return.
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 1, 1);
    for (int i = 0; i < 9; i++) send(8'h20 + i, 7, 7);
    send(8'h07, 2, 2);
    check("t5_bel_we", int'(we), 0);
    check_cur("t5_bel_cur", 2, 9);
    send(8'h0D, 2, 2);
    check("t5_cr_we", int'(we), 0);
    check_cur("t5_cr_cur", 2, 0);

    // Test 6: reset in the middle of a row clear.
    send(8'h0A, 5, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 10; i++) @(negedge clk);
    send(8'h5A, 5, 6);
    check("t6_we", int'(we), 1);
    check("t6_addr", int'({wr_addr, wc_addr}), 0);
    check("t6_colors", int'({w_fg_color, w_bg_color}), {3'd5, 3'd6});
    check_cur("t6_cur", 0, 1);

    n = 0;
    while (q.size() > 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
